// File: rtl/shiftr_pkg.sv
// Shared constants, width helpers and the snapshot layout handed to the back-end decoder.
// Snapshot bundle is packed {overflow, count, bits, therm}, MSB to LSB.
package shiftr_pkg;

   localparam int DEPTH_DEF       = 10;
   localparam int FRAME_LEN_DEF   = 16;
   localparam int SYNC_STAGES_DEF = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int snap_w(input int depth);
      return 1 + clog2(depth + 1) + 2 * depth;
   endfunction

   typedef struct packed {
      logic                               overflow;
      logic [clog2(DEPTH_DEF + 1)-1:0]    count;
      logic [DEPTH_DEF-1:0]               bits;
      logic [DEPTH_DEF-1:0]               therm;
   } snap_t;

endpackage

// File: rtl/shiftr_sync.sv
// STAGES-deep flop chain bringing an asynchronous comparator output into the clock domain.
// Latency STAGES cycles; no flow control.
module shiftr_sync
   import shiftr_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clock,
   input  logic res,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stg;

   always_ff @(posedge clock) begin
      if (res) begin
         stg <= '0;
      end else begin
         stg <= {stg[STAGES-2:0], d};
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/shiftr_frame_tdc.sv
// Comparator event thermometer with per-frame snapshot; event acted on SYNC_STAGES+1 cycles after input change.
// No backpressure: en=0 pauses the frame and holds the comparator in reset.
module shiftr_frame_tdc
   import shiftr_pkg::*;
#(
   parameter int  DEPTH       = DEPTH_DEF,
   parameter int  FRAME_LEN   = FRAME_LEN_DEF,
   parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int CNT_W       = clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             res,
   input  logic             en,
   input  logic             outp,
   input  logic             outn,
   output logic [DEPTH-1:0] therm,
   output logic [DEPTH-1:0] bits,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             frame_done,
   output logic             creset
);

   localparam int               FC_W     = clog2(FRAME_LEN);
   localparam int               SNAP_W   = snap_w(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_LEN - 1);

   logic              p_s;
   logic              n_s;
   logic              valid_s;
   logic              valid_d;
   logic              full_d;
   logic              ev;
   logic              last;

   logic [DEPTH-1:0]  live_th;
   logic [DEPTH-1:0]  live_bits;
   logic [CNT_W-1:0]  live_cnt;
   logic              live_ovf;
   logic [FC_W-1:0]   fc;

   logic [DEPTH-1:0]  th_nx;
   logic [DEPTH-1:0]  bits_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic              ovf_nx;

   logic [SNAP_W-1:0] snap_q;
   logic [SNAP_W-1:0] snap_nx;

   shiftr_sync #(.STAGES(SYNC_STAGES)) u_sync_p (
      .clock (clock),
      .res   (res),
      .d     (outp),
      .q     (p_s)
   );

   shiftr_sync #(.STAGES(SYNC_STAGES)) u_sync_n (
      .clock (clock),
      .res   (res),
      .d     (outn),
      .q     (n_s)
   );

   assign valid_s = p_s ^ n_s;
   assign ev      = valid_s & ~valid_d & en;
   assign last    = (fc == FC_LAST) & en;

   // Next live state; the snapshot takes this so an event on the last cycle is kept.
   always_comb begin
      th_nx   = live_th;
      bits_nx = live_bits;
      cnt_nx  = live_cnt;
      ovf_nx  = live_ovf;
      if (ev) begin
         if (live_cnt == CNT_FULL) begin
            ovf_nx = 1'b1;
         end else begin
            th_nx   = {live_th[DEPTH-2:0], 1'b1};
            bits_nx = {live_bits[DEPTH-2:0], p_s};
            cnt_nx  = live_cnt + CNT_W'(1);
         end
      end
   end

   assign snap_nx = {ovf_nx, cnt_nx, bits_nx, th_nx};

   always_ff @(posedge clock) begin
      if (res) begin
         valid_d    <= 1'b0;
         full_d     <= 1'b0;
         frame_done <= 1'b0;
         fc         <= '0;
         live_th    <= '0;
         live_bits  <= '0;
         live_cnt   <= '0;
         live_ovf   <= 1'b0;
         snap_q     <= '0;
      end else begin
         valid_d    <= valid_s;
         full_d     <= (live_cnt == CNT_FULL);
         frame_done <= last;
         if (en) begin
            if (last) begin
               snap_q    <= snap_nx;
               fc        <= '0;
               live_th   <= '0;
               live_bits <= '0;
               live_cnt  <= '0;
               live_ovf  <= 1'b0;
            end else begin
               fc        <= fc + FC_W'(1);
               live_th   <= th_nx;
               live_bits <= bits_nx;
               live_cnt  <= cnt_nx;
               live_ovf  <= ovf_nx;
            end
         end
      end
   end

   assign {overflow, count, bits, therm} = snap_q;

   // Comparator stays in reset while a decision is pending, the thermometer is full or a frame is closing.
   assign creset = res | ~en | valid_d | full_d | frame_done;

endmodule
